// File: rtl/es_pkg.sv
// Shared encodings for the ex_stack driver: command opcodes, stack port opcodes,
// error codes, FSM states and the default stack depth.
package es_pkg;

  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_DUP     = 3'd2,
    OP_SWAP    = 3'd3,
    OP_PEEK    = 3'd4,
    OP_POPREAD = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_ILLEGAL = 3'd7
  } cmd_op_t;

  typedef enum logic [1:0] {
    ES_PUSH = 2'd0,
    ES_POP  = 2'd1,
    ES_DUP  = 2'd2,
    ES_SWAP = 2'd3
  } es_op_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SETTLE,
    S_READ,
    S_CLR
  } state_t;

endpackage

// File: rtl/es_legal.sv
// Combinational legality check of a command against the current shadow depth.
// Overflow takes priority over underflow.
module es_legal
  import es_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic [2:0] op,
  input  logic [1:0] arg,
  input  logic [5:0] depth,
  output logic       ok,
  output logic [1:0] err_code
);

  localparam logic [6:0] DEPTH_CAP = 7'(DEPTH);

  logic [6:0] need;
  logic [6:0] grow;
  logic [6:0] total;

  always_comb begin
    need = 7'd0;
    grow = 7'd0;
    case (op)
      OP_PUSH:             grow = 7'd1;
      OP_POP:              need = arg[0] ? 7'd2 : 7'd1;
      OP_DUP: begin
        need = {5'd0, arg} + 7'd1;
        grow = {5'd0, arg} + 7'd1;
      end
      OP_SWAP:             need = 7'd2;
      OP_PEEK, OP_POPREAD: need = 7'd1;
      default: ;
    endcase

    total    = {1'b0, depth} + grow;
    ok       = 1'b1;
    err_code = ERR_NONE;
    if (op == OP_ILLEGAL) begin
      ok       = 1'b0;
      err_code = ERR_ILLEGAL;
    end else if (total > DEPTH_CAP) begin
      ok       = 1'b0;
      err_code = ERR_OVERFLOW;
    end else if ({1'b0, depth} < need) begin
      ok       = 1'b0;
      err_code = ERR_UNDERFLOW;
    end
  end

endmodule

// File: rtl/es_driver.sv
// Command front end for an external ex_stack: validates commands against a shadow
// depth, sequences the registered stack port and returns read responses.
module es_driver
  import es_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_arg,
  input  logic [W-1:0] cmd_data,
  output logic         ESAct,
  output logic [1:0]   ESOp,
  output logic [W-1:0] pushVal,
  output logic         popNum,
  output logic [1:0]   dupNum,
  input  logic [W-1:0] outA,
  input  logic [W-1:0] outB,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_a,
  output logic [W-1:0] rsp_b,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [5:0]   depth
);

  state_t     state;
  logic       popread_pending;
  logic       legal_ok;
  logic [1:0] legal_err;
  logic [5:0] pop_amt;
  logic [5:0] exec_depth;
  logic [5:0] clr_left;

  es_legal #(.DEPTH(DEPTH)) u_legal (
    .op       (cmd_op),
    .arg      (cmd_arg),
    .depth    (depth),
    .ok       (legal_ok),
    .err_code (legal_err)
  );

  assign cmd_ready = (state == S_IDLE);

  // Depth after the stack operation currently on the port completes.
  always_comb begin
    pop_amt    = popNum ? 6'd2 : 6'd1;
    clr_left   = depth - pop_amt;
    exec_depth = depth;
    case (ESOp)
      ES_PUSH: exec_depth = depth + 6'd1;
      ES_POP:  exec_depth = depth - pop_amt;
      ES_DUP:  exec_depth = depth + {4'd0, dupNum} + 6'd1;
      default: exec_depth = depth;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      popread_pending <= 1'b0;
      depth           <= 6'd0;
      ESAct           <= 1'b0;
      ESOp            <= ES_PUSH;
      pushVal         <= '0;
      popNum          <= 1'b0;
      dupNum          <= 2'd0;
      rsp_valid       <= 1'b0;
      rsp_a           <= '0;
      rsp_b           <= '0;
      err             <= 1'b0;
      err_code        <= ERR_NONE;
    end else begin
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (!legal_ok) begin
              err      <= 1'b1;
              err_code <= legal_err;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  state   <= S_EXEC;
                  ESAct   <= 1'b1;
                  ESOp    <= ES_PUSH;
                  pushVal <= cmd_data;
                end
                OP_POP: begin
                  state  <= S_EXEC;
                  ESAct  <= 1'b1;
                  ESOp   <= ES_POP;
                  popNum <= cmd_arg[0];
                end
                OP_DUP: begin
                  state  <= S_EXEC;
                  ESAct  <= 1'b1;
                  ESOp   <= ES_DUP;
                  dupNum <= cmd_arg;
                end
                OP_SWAP: begin
                  state <= S_EXEC;
                  ESAct <= 1'b1;
                  ESOp  <= ES_SWAP;
                end
                OP_PEEK, OP_POPREAD: begin
                  state           <= S_READ;
                  popread_pending <= (cmd_op == OP_POPREAD);
                end
                OP_CLEAR: begin
                  if (depth == 6'd0) begin
                    state <= S_SETTLE;
                  end else begin
                    state  <= S_CLR;
                    ESAct  <= 1'b1;
                    ESOp   <= ES_POP;
                    popNum <= (depth >= 6'd2);
                  end
                end
                default: ;
              endcase
            end
          end
        end

        S_EXEC: begin
          depth   <= exec_depth;
          state   <= S_SETTLE;
          ESAct   <= 1'b0;
          ESOp    <= ES_PUSH;
          pushVal <= '0;
          popNum  <= 1'b0;
          dupNum  <= 2'd0;
        end

        S_SETTLE: state <= S_IDLE;

        S_READ: begin
          rsp_a     <= outA;
          rsp_b     <= outB;
          rsp_valid <= 1'b1;
          if (popread_pending) begin
            state  <= S_EXEC;
            ESAct  <= 1'b1;
            ESOp   <= ES_POP;
            popNum <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
          popread_pending <= 1'b0;
        end

        // Pops two per cycle while possible; the last one may be a single pop.
        S_CLR: begin
          depth <= clr_left;
          if (clr_left == 6'd0) begin
            state  <= S_SETTLE;
            ESAct  <= 1'b0;
            ESOp   <= ES_PUSH;
            popNum <= 1'b0;
          end else begin
            popNum <= (clr_left >= 6'd2);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_es_driver.sv
// Randomized bench for es_driver: an ex_stack model answers the stack port and a
// queue-based reference predicts responses, errors, stack traffic and depth.
module tb_es_driver;

  localparam int DEPTH = 32;
  localparam int W     = 16;

  localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_DUP = 3'd2, C_SWAP = 3'd3,
                         C_PEEK = 3'd4, C_POPREAD = 3'd5, C_CLEAR = 3'd6, C_BAD = 3'd7;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_arg;
  logic [W-1:0] cmd_data;
  logic         ESAct;
  logic [1:0]   ESOp;
  logic [W-1:0] pushVal;
  logic         popNum;
  logic [1:0]   dupNum;
  logic [W-1:0] outA;
  logic [W-1:0] outB;
  logic         rsp_valid;
  logic [W-1:0] rsp_a;
  logic [W-1:0] rsp_b;
  logic         err;
  logic [1:0]   err_code;
  logic [5:0]   depth;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  logic [W-1:0] ref_q[$];

  es_driver #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_data(cmd_data),
    .ESAct(ESAct), .ESOp(ESOp), .pushVal(pushVal), .popNum(popNum), .dupNum(dupNum),
    .outA(outA), .outB(outB), .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .err(err), .err_code(err_code), .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ex_stack model: applies each ESAct cycle to an array stack.
  logic [W-1:0] stk [0:127];
  logic [6:0]   sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 7'd0;
    end else if (ESAct) begin
      case (ESOp)
        2'd0: begin stk[sp] <= pushVal; sp <= sp + 7'd1; end
        2'd1: sp <= sp - (popNum ? 7'd2 : 7'd1);
        2'd2: begin
          for (int i = 0; i <= int'(dupNum); i++)
            stk[sp + 7'(i)] <= stk[sp - 7'(dupNum) - 7'd1 + 7'(i)];
          sp <= sp + 7'(dupNum) + 7'd1;
        end
        default: begin
          stk[sp - 7'd1] <= stk[sp - 7'd2];
          stk[sp - 7'd2] <= stk[sp - 7'd1];
        end
      endcase
    end
  end
  assign outA = stk[sp - 7'd1];
  assign outB = stk[sp - 7'd2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn, got, exp);
    end
  endtask

  function automatic int pk(int o, int p, int dn, int pv);
    return (o << 19) | (p << 18) | (dn << 16) | pv;
  endfunction

  function automatic int exp_err(logic [2:0] op, logic [1:0] arg, int d);
    case (op)
      C_PUSH:    return (d >= DEPTH) ? 1 : 0;
      C_POP:     return (d < (arg[0] ? 2 : 1)) ? 2 : 0;
      C_DUP:     return (d + int'(arg) + 1 > DEPTH) ? 1 : ((d < int'(arg) + 1) ? 2 : 0);
      C_SWAP:    return (d < 2) ? 2 : 0;
      C_PEEK, C_POPREAD: return (d < 1) ? 2 : 0;
      C_CLEAR:   return 0;
      default:   return 3;
    endcase
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] arg, input logic [W-1:0] data);
    int d, e, n, rem, w, k, exp_lat, exp_rsp_k, exp_act_k;
    int obs_act_k, obs_rsp_k, rsp_cnt, err_cnt, obs_err_code;
    logic [W-1:0] top, nxt, got_a, got_b, tmp;
    int exp_f[$];
    int obs_f[$];

    d = ref_q.size();
    e = exp_err(op, arg, d);
    top = (d >= 1) ? ref_q[d-1] : '0;
    nxt = (d >= 2) ? ref_q[d-2] : '0;
    exp_rsp_k = 0;
    exp_act_k = 1;
    exp_lat   = 3;
    if (e != 0) begin
      exp_lat = 1;
    end else begin
      case (op)
        C_PUSH: begin exp_f.push_back(pk(0, 0, 0, int'(data))); ref_q.push_back(data); end
        C_POP: begin
          exp_f.push_back(pk(1, int'(arg[0]), 0, 0));
          void'(ref_q.pop_back());
          if (arg[0]) void'(ref_q.pop_back());
        end
        C_DUP: begin
          n = int'(arg);
          exp_f.push_back(pk(2, 0, n, 0));
          for (int i = 0; i <= n; i++) ref_q.push_back(ref_q[d-n-1+i]);
        end
        C_SWAP: begin
          exp_f.push_back(pk(3, 0, 0, 0));
          tmp = ref_q[d-1]; ref_q[d-1] = ref_q[d-2]; ref_q[d-2] = tmp;
        end
        C_PEEK: begin exp_lat = 2; exp_rsp_k = 2; end
        C_POPREAD: begin
          exp_lat = 4; exp_rsp_k = 2; exp_act_k = 2;
          exp_f.push_back(pk(1, 0, 0, 0));
          void'(ref_q.pop_back());
        end
        default: begin
          rem = d;
          while (rem > 0) begin
            exp_f.push_back(pk(1, (rem >= 2) ? 1 : 0, 0, 0));
            rem -= (rem >= 2) ? 2 : 1;
          end
          exp_lat = exp_f.size() + 2;
          ref_q.delete();
        end
      endcase
    end

    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check_val("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_data = data;

    k = 0; obs_act_k = 0; obs_rsp_k = 0; rsp_cnt = 0; err_cnt = 0; obs_err_code = 0;
    got_a = '0; got_b = '0;
    do begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      if (ESAct) begin
        if (obs_f.size() == 0) obs_act_k = k;
        obs_f.push_back(pk(int'(ESOp), int'(popNum), int'(dupNum), int'(pushVal)));
      end
      if (rsp_valid) begin rsp_cnt++; obs_rsp_k = k; got_a = rsp_a; got_b = rsp_b; end
      if (err) begin err_cnt++; obs_err_code = int'(err_code); end
    end while (!cmd_ready && k < 100);

    check_val("latency", 32'(k), 32'(exp_lat));
    check_val("esact_count", 32'(obs_f.size()), 32'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < obs_f.size(); i++)
      check_val("esact_fields", 32'(obs_f[i]), 32'(exp_f[i]));
    if (exp_f.size() > 0) check_val("esact_cycle", 32'(obs_act_k), 32'(exp_act_k));
    check_val("err_pulses", 32'(err_cnt), (e != 0) ? 32'd1 : 32'd0);
    if (e != 0) check_val("err_code", 32'(obs_err_code), 32'(e));
    check_val("rsp_pulses", 32'(rsp_cnt), (exp_rsp_k != 0) ? 32'd1 : 32'd0);
    if (exp_rsp_k != 0) begin
      check_val("rsp_cycle", 32'(obs_rsp_k), 32'(exp_rsp_k));
      check_val("rsp_a", 32'(got_a), 32'(top));
      if (d >= 2) check_val("rsp_b", 32'(got_b), 32'(nxt));
    end
    check_val("depth", 32'(depth), 32'(ref_q.size()));
    $display("txn %0d op=%0d arg=%0d data=%h depth %0d->%0d acts=%0d lat=%0d err=%0d",
             txn, op, arg, data, d, ref_q.size(), obs_f.size(), k, obs_err_code);
    txn++;
  endtask

  initial begin
    int r;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 2'd0; cmd_data = '0;
    #1 rst = 1'b1;
    #1;
    check_val("reset_esact", 32'(ESAct), 32'd0);
    check_val("reset_depth", 32'(depth), 32'd0);
    check_val("reset_err", 32'({err, err_code}), 32'd0);
    check_val("reset_rsp", 32'({rsp_valid, rsp_a, rsp_b}), 32'd0);
    check_val("reset_fields", 32'({ESOp, pushVal, popNum, dupNum}), 32'd0);
    check_val("reset_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    do_cmd(C_POP, 2'd0, '0);
    do_cmd(C_PUSH, 2'd0, 16'h1234);
    do_cmd(C_SWAP, 2'd0, '0);
    do_cmd(C_PUSH, 2'd0, 16'hBEEF);
    do_cmd(C_PEEK, 2'd0, '0);
    do_cmd(C_BAD, 2'd0, '0);
    do_cmd(C_CLEAR, 2'd0, '0);
    do_cmd(C_CLEAR, 2'd0, '0);
    for (int i = 0; i < DEPTH; i++) do_cmd(C_PUSH, 2'd0, 16'($urandom));
    do_cmd(C_PUSH, 2'd0, 16'hDEAD);
    do_cmd(C_DUP, 2'd0, '0);
    do_cmd(C_PEEK, 2'd0, '0);
    do_cmd(C_CLEAR, 2'd0, '0);
    for (int i = 0; i < 5; i++) do_cmd(C_PUSH, 2'd0, 16'($urandom));
    do_cmd(C_CLEAR, 2'd0, '0);
    for (int i = 0; i < 3; i++) do_cmd(C_PUSH, 2'd0, 16'($urandom));
    do_cmd(C_DUP, 2'd1, '0);
    do_cmd(C_PEEK, 2'd0, '0);
    do_cmd(C_POPREAD, 2'd0, '0);
    do_cmd(C_POP, 2'd1, '0);
    do_cmd(C_DUP, 2'd3, '0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (r <= 6)       do_cmd(C_PUSH, 2'($urandom), 16'($urandom));
      else if (r <= 9)  do_cmd(C_POP, 2'($urandom), '0);
      else if (r <= 11) do_cmd(C_DUP, 2'($urandom), '0);
      else if (r <= 13) do_cmd(C_SWAP, 2'd0, '0);
      else if (r <= 15) do_cmd(C_PEEK, 2'd0, '0);
      else if (r <= 17) do_cmd(C_POPREAD, 2'd0, '0);
      else if (r == 18) do_cmd(C_CLEAR, 2'd0, '0);
      else              do_cmd(C_BAD, 2'($urandom), '0);
    end

    // Reset in the middle of a CLEAR at depth 20
    do_cmd(C_CLEAR, 2'd0, '0);
    for (int i = 0; i < 20; i++) do_cmd(C_PUSH, 2'd0, 16'($urandom));
    cmd_valid = 1'b1; cmd_op = C_CLEAR; cmd_arg = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("clr_active", 32'(ESAct), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midreset_esact", 32'(ESAct), 32'd0);
    check_val("midreset_depth", 32'(depth), 32'd0);
    check_val("midreset_ready", 32'(cmd_ready), 32'd1);
    ref_q.delete();
    @(negedge clk);
    rst = 1'b0;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || err || ESAct) r++;
    end
    check_val("midreset_quiet", 32'(r), 32'd0);
    do_cmd(C_PUSH, 2'd0, 16'h5A5A);
    do_cmd(C_PEEK, 2'd0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/es_driver.md
ES_DRIVER -- requirements
Module: es_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of ex_stack entries.
REQ-002 SHALL have parameter W, default 16, stack data width.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered; cmd_ready  output  1  driver accepts command.
REQ-006 cmd_op  input  3  0 PUSH, 1 POP, 2 DUP, 3 SWAP, 4 PEEK, 5 POPREAD, 6 CLEAR, 7 illegal.
REQ-007 cmd_arg  input  2  POP: bit0=0 pop one, 1 pop two; DUP: n copies top n+1 entries.
REQ-008 cmd_data  input  W  PUSH value.
REQ-009 ESAct  output  1, ESOp  output  2, pushVal  output  W, popNum  output  1, dupNum  output  2  stack command port; all registered.
REQ-010 outA, outB  input  W  stack top and next-to-top.
REQ-011 rsp_valid  output  1, rsp_a  output  W, rsp_b  output  W  read response.
REQ-012 err  output  1, err_code  output  2  (1 overflow, 2 underflow, 3 illegal op).
REQ-013 depth  output  6  entries currently on stack (shadow count).

Function
REQ-014 ESOp encodings SHALL be PUSH=0, POP=1, DUP=2, SWAP=3; ESAct high exactly one cycle per stack operation.
REQ-015 States SHALL be IDLE, EXEC, SETTLE, READ, CLR; cmd_ready=1 only in IDLE.
REQ-016 Accept = cmd_valid && cmd_ready at a posedge; legality checked on the accepting edge against current depth.
REQ-017 Legal iff: PUSH depth<DEPTH; POP one depth>=1, two depth>=2; DUP depth>=n+1 and depth+n+1<=DEPTH; SWAP depth>=2; PEEK/POPREAD depth>=1; CLEAR always.
REQ-018 Illegal accept: no ESAct, state stays IDLE, err=1 with err_code for exactly the next cycle; overflow checked before underflow.
REQ-019 PUSH/POP/DUP/SWAP: IDLE->EXEC (ESAct=1, fields driven) ->SETTLE (ESAct=0) ->IDLE; cmd_ready returns 3 cycles after accept.
REQ-020 depth SHALL update on the edge ending EXEC: PUSH +1, POP -1/-2, DUP +(n+1), SWAP 0.
REQ-021 PEEK: IDLE->READ->IDLE; outA/outB sampled into rsp_a/rsp_b at the edge ending READ; rsp_valid=1 for exactly the following cycle.
REQ-022 POPREAD: IDLE->READ->EXEC (POP one)->SETTLE->IDLE; rsp_valid high during EXEC cycle.
REQ-023 CLEAR with depth=0: IDLE->SETTLE->IDLE, no ESAct.
REQ-024 CLEAR with depth>0: CLR issues ESAct every cycle, POP with popNum=1 while depth>=2, popNum=0 when depth=1; then SETTLE->IDLE; ceil(depth/2) ESAct cycles.
REQ-025 Fields not used by an op SHALL be driven 0; pushVal holds cmd_data only for PUSH.
REQ-026 depth SHALL never exceed DEPTH or go below 0; rsp_b is undefined-by-stack but still captured when depth=1.

Reset
REQ-027 On reset assertion, state=IDLE, depth=0, ESAct=0, all other outputs 0, immediately and asynchronously.
REQ-028 Reset mid-operation SHALL abandon the command with no response or err pulse; ex_stack shares the reset net.
REQ-029 After reset release cmd_ready=1 from the first clk edge.

Structure
REQ-030 Package es_pkg SHALL hold cmd_op codes, ESOp codes, err_code values, state enum, and DEPTH default.
REQ-031 Legality check SHALL be one combinational sub-module es_legal (inputs op, arg, depth; outputs ok, err_code).

Verification
REQ-032 PUSH 0x1234, PUSH 0xBEEF, PEEK -> rsp_a=0xBEEF, rsp_b=0x1234, depth=2.
REQ-033 32 PUSHes then PUSH -> 33rd: err=1, err_code=1, no ESAct, depth=32.
REQ-034 After reset, POP one -> err_code=2; SWAP with depth=1 -> err_code=2.
REQ-035 depth=5, CLEAR -> 3 consecutive ESAct cycles, popNum 1,1,0; depth=0; cmd_ready after SETTLE.
REQ-036 depth=3, DUP n=1 -> one ESAct with ESOp=2, dupNum=1; depth=5; PEEK returns the copied top two.
REQ-037 Reset asserted during CLR at depth=20 -> ESAct low same cycle, depth=0, no rsp_valid/err.
